alu16_arbiter: RTL
==================

// Module: alu16_arbiter
// PURPOSE
//   Round-robin scheduler that shares one alu16 between NREQ requesters.
//   - Accepts operand/op requests on valid/ready handshakes and fires the ALU with an on-pulse.
//   - Waits for the ALU's count to signal completion, then returns the 17-bit result tagged with the requester id.
//   - Sits between the issuing blocks and the alu16 instance; drives every alu16 input.
// PARAMETERS
//   NREQ        4   number of requesters (2..8)
//   IDW         2   requester id width, clog2(NREQ)
//   ON_CYCLES   2   clk cycles alu_on is held high per operation (>=1)
//   DONE_COUNT  15  alu_count value that marks a finished operation
// PORTS
//   clk         in   1         system clock, all logic on posedge
//   rst         in   1         asynchronous, active-high reset
//   req_valid   in   NREQ      per-requester request valid
//   req_ready   out  NREQ      per-requester accept; one-hot or zero
//   req_ina     in   NREQ*16   operand A, requester k at [16k+15:16k]
//   req_inb     in   NREQ*16   operand B, same packing
//   req_op      in   NREQ*3    opcode, requester k at [3k+2:3k]
//   resp_valid  out  1         result available
//   resp_ready  in   1         consumer accepts result
//   resp_id     out  IDW       requester that issued the result
//   resp_data   out  17        ALU result, 17 bits including carry
//   busy        out  1         high in any state other than IDLE
//   alu_on      out  1         start pulse to alu16.on
//   alu_ina     out  16        to alu16.ina, held stable from START through CAPTURE
//   alu_inb     out  16        to alu16.inb
//   alu_op      out  3         to alu16.op
//   alu_out     in   17        from alu16.out
//   alu_count   in   4         from alu16.count
// BEHAVIOUR
//   - Reset (async): state=IDLE, all outputs 0, rr pointer=0, timers 0.
//   - FSM states: IDLE -> START -> WAIT -> CAPTURE -> RESP -> IDLE.
//   - IDLE, grant selection:
//     - If any req_valid is high, grant the first valid requester at or after the rr pointer, wrapping NREQ-1 -> 0.
//     - req_ready[g] is high combinationally for that single cycle; all other bits stay 0.
//     - Latch ina/inb/op into alu_* and latch g as resp_id; rr pointer <= g+1 mod NREQ.
//     - Go to START.
//   - START: alu_on=1 for exactly ON_CYCLES cycles, then alu_on=0 and go to WAIT.
//   - WAIT: when alu_count==DONE_COUNT, go to CAPTURE. alu16 clears its count on the on-pulse, so no stale match is possible.
//   - CAPTURE: one cycle; resp_data <= alu_out; go to RESP.
//   - RESP:
//     - resp_valid=1 with resp_data/resp_id stable until resp_ready.
//     - On the valid&&ready cycle: resp_valid <= 0 next cycle and return to IDLE.
//     - A new grant can occur no earlier than the cycle after the return to IDLE.
//   - Throughput: at most one operation in flight; no request is accepted outside IDLE.
//   - Latency, grant to resp_valid: 1 + ON_CYCLES + (cycles until count==DONE_COUNT) + 1.
//   - Requests: req_valid may drop without being granted; the arbiter ignores it.
//   - resp_ready held high: RESP lasts exactly one cycle.
//   - rst mid-operation: immediate return to IDLE, alu_on=0, result discarded, rr pointer=0.
// CONFIGURATION
//   ALU_ARB_TIMEOUT_EN defined:
//     - Adds parameter TIMEOUT (default 64) and output resp_err (1 bit, reset 0).
//     - A WAIT-cycle counter runs in WAIT. If it reaches TIMEOUT before done, go to RESP with resp_data=0 and resp_err=1.
//     - resp_err is valid with resp_valid; it is 0 for normal results.
//   ALU_ARB_TIMEOUT_EN undefined:
//     - No counter and no resp_err port; WAIT waits indefinitely.
// TESTING
//   1. Single request:
//      - Stimulus: rst pulse, then req0 with ina=16'h7003, inb=16'hC003, op=3'b011.
//      - Required: req_ready[0] for 1 cycle; alu_on high 2 cycles; resp_valid with resp_id=0 and resp_data equal to the alu16 output at count==15.
//   2. All four requesters valid continuously, resp_ready=1:
//      - Required: grant order 0,1,2,3,0 and resp_id matches that order.
//   3. Backpressure:
//      - Stimulus: hold resp_ready=0 for 10 cycles in RESP.
//      - Required: resp_valid and resp_data stable; req_ready stays 0; exactly one response after release.
//   4. Pointer wrap:
//      - Stimulus: only req3 valid, then req3 and req1 valid.
//      - Required: grant 3, then grant 1.
//   5. Reset mid-operation:
//      - Stimulus: assert rst during WAIT.
//      - Required: alu_on=0, resp_valid=0, busy=0 immediately; next req2 is served normally with resp_id=2.
//   6. ALU_ARB_TIMEOUT_EN, TIMEOUT=64:
//      - Stimulus: stub alu_count stuck at 0.
//      - Required: after 64 WAIT cycles, resp_valid=1 with resp_err=1 and resp_data=0.

Source files
------------

// File: rtl/alu16_arbiter_if.sv
// Bundle between the issuing blocks, the alu16 instance and the arbiter.
// resp_err exists only when ALU_ARB_TIMEOUT_EN is defined.
interface alu16_arbiter_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*16-1:0] req_ina;
   logic [NREQ*16-1:0] req_inb;
   logic [NREQ*3-1:0]  req_op;
   logic               resp_valid;
   logic               resp_ready;
   logic [IDW-1:0]     resp_id;
   logic [16:0]        resp_data;
   logic               busy;
   logic               alu_on;
   logic [15:0]        alu_ina;
   logic [15:0]        alu_inb;
   logic [2:0]         alu_op;
   logic [16:0]        alu_out;
   logic [3:0]         alu_count;
`ifdef ALU_ARB_TIMEOUT_EN
   logic               resp_err;
`endif

   modport slave (
      input  req_valid, req_ina, req_inb, req_op, resp_ready, alu_out, alu_count,
      output req_ready, resp_valid, resp_id, resp_data, busy, alu_on, alu_ina, alu_inb, alu_op
`ifdef ALU_ARB_TIMEOUT_EN
      , output resp_err
`endif
   );

   modport master (
      output req_valid, req_ina, req_inb, req_op, resp_ready, alu_out, alu_count,
      input  req_ready, resp_valid, resp_id, resp_data, busy, alu_on, alu_ina, alu_inb, alu_op
`ifdef ALU_ARB_TIMEOUT_EN
      , input resp_err
`endif
   );
endinterface

// File: rtl/alu16_arbiter.sv
// Round-robin scheduler sharing one alu16 among NREQ requesters, one op in flight.
// Optional feature macro ALU_ARB_TIMEOUT_EN: WAIT timeout with resp_err reporting.
module alu16_arbiter #(
   parameter int NREQ       = 4,
   parameter int IDW        = 2,
   parameter int ON_CYCLES  = 2,
   parameter int DONE_COUNT = 15
`ifdef ALU_ARB_TIMEOUT_EN
   ,
   parameter int TIMEOUT    = 64
`endif
) (
   input logic            clk,
   input logic            rst,
   alu16_arbiter_if.slave bus
);

   localparam int ONW = (ON_CYCLES > 1) ? $clog2(ON_CYCLES) : 1;

   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_WAIT, ST_CAPTURE, ST_RESP} state_t;

   state_t          state_reg, state_next;
   logic [ONW-1:0]  on_cnt_reg;
   logic [IDW-1:0]  rr_ptr_reg;
   logic [15:0]     alu_ina_reg, alu_inb_reg;
   logic [2:0]      alu_op_reg;
   logic [IDW-1:0]  resp_id_reg;
   logic [16:0]     resp_data_reg;

   logic [15:0]     ina_arr [NREQ];
   logic [15:0]     inb_arr [NREQ];
   logic [2:0]      op_arr  [NREQ];
   logic            grant_found;
   logic [IDW-1:0]  grant_id, rr_next;
   logic            on_last, alu_done;
   logic [NREQ-1:0] req_ready;
   logic            alu_on, resp_valid, busy;

`ifdef ALU_ARB_TIMEOUT_EN
   localparam int TOW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [TOW-1:0]  wait_cnt_reg;
   logic            resp_err_reg;
   logic            timeout_hit;

   assign timeout_hit  = (wait_cnt_reg == TOW'(TIMEOUT - 1));
   assign bus.resp_err = resp_err_reg;
`endif

   // Stage gi looks at requester (rr_ptr + gi) mod NREQ; the first stage with a hit wins.
   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_req
         logic [IDW:0]   cand_sum;
         logic [IDW-1:0] cand_idx;
         logic           hit, seen_out;
         logic [IDW-1:0] id_out;

         assign ina_arr[gi] = bus.req_ina[16*gi +: 16];
         assign inb_arr[gi] = bus.req_inb[16*gi +: 16];
         assign op_arr[gi]  = bus.req_op[3*gi +: 3];

         assign cand_sum = {1'b0, rr_ptr_reg} + (IDW+1)'(gi);
         assign cand_idx = (cand_sum >= (IDW+1)'(NREQ)) ? IDW'(cand_sum - (IDW+1)'(NREQ))
                                                         : cand_sum[IDW-1:0];
         assign hit      = bus.req_valid[cand_idx];

         if (gi == 0) begin : g_first
            assign seen_out = hit;
            assign id_out   = cand_idx;
         end else begin : g_rest
            assign seen_out = g_req[gi-1].seen_out | hit;
            assign id_out   = g_req[gi-1].seen_out ? g_req[gi-1].id_out : cand_idx;
         end
      end
   endgenerate

   assign grant_found = g_req[NREQ-1].seen_out;
   assign grant_id    = g_req[NREQ-1].id_out;
   assign rr_next     = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
   assign on_last     = (on_cnt_reg == ONW'(ON_CYCLES - 1));
   assign alu_done    = (bus.alu_count == 4'(DONE_COUNT));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= ST_IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:    if (grant_found) state_next = ST_START;
         ST_START:   if (on_last) state_next = ST_WAIT;
         ST_WAIT: begin
            if (alu_done) state_next = ST_CAPTURE;
`ifdef ALU_ARB_TIMEOUT_EN
            else if (timeout_hit) state_next = ST_RESP;
`endif
         end
         ST_CAPTURE: state_next = ST_RESP;
         ST_RESP:    if (bus.resp_ready) state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   // req_ready is masked during reset so every output reads 0 while rst is high.
   always_comb begin
      req_ready  = '0;
      alu_on     = 1'b0;
      resp_valid = 1'b0;
      busy       = 1'b1;
      case (state_reg)
         ST_IDLE: begin
            busy = 1'b0;
            if (grant_found && !rst) req_ready[grant_id] = 1'b1;
         end
         ST_START: alu_on     = 1'b1;
         ST_RESP:  resp_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         on_cnt_reg    <= '0;
         rr_ptr_reg    <= '0;
         alu_ina_reg   <= '0;
         alu_inb_reg   <= '0;
         alu_op_reg    <= '0;
         resp_id_reg   <= '0;
         resp_data_reg <= '0;
`ifdef ALU_ARB_TIMEOUT_EN
         wait_cnt_reg  <= '0;
         resp_err_reg  <= 1'b0;
`endif
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (grant_found) begin
                  alu_ina_reg <= ina_arr[grant_id];
                  alu_inb_reg <= inb_arr[grant_id];
                  alu_op_reg  <= op_arr[grant_id];
                  resp_id_reg <= grant_id;
                  rr_ptr_reg  <= rr_next;
                  on_cnt_reg  <= '0;
`ifdef ALU_ARB_TIMEOUT_EN
                  wait_cnt_reg <= '0;
                  resp_err_reg <= 1'b0;
`endif
               end
            end
            ST_START: on_cnt_reg <= on_cnt_reg + 1'b1;
`ifdef ALU_ARB_TIMEOUT_EN
            ST_WAIT: begin
               wait_cnt_reg <= wait_cnt_reg + 1'b1;
               if (timeout_hit && !alu_done) begin
                  resp_data_reg <= '0;
                  resp_err_reg  <= 1'b1;
               end
            end
`endif
            ST_CAPTURE: resp_data_reg <= bus.alu_out;
            default: ;
         endcase
      end
   end

   assign bus.req_ready  = req_ready;
   assign bus.resp_valid = resp_valid;
   assign bus.resp_id    = resp_id_reg;
   assign bus.resp_data  = resp_data_reg;
   assign bus.busy       = busy;
   assign bus.alu_on     = alu_on;
   assign bus.alu_ina    = alu_ina_reg;
   assign bus.alu_inb    = alu_inb_reg;
   assign bus.alu_op     = alu_op_reg;

endmodule
